ram3_arb: RTL and testbench

Two-port access controller for the 1K x 8 single-port RAM (`ram3`): `cs`, `wr`, 10-bit `addr`, 8-bit `data_in`, combinational `data_out`. Two independent requesters (port 0, port 1) issue single-word read/write transactions through a req/ack handshake. The block arbitrates between them, sequences one RAM access per transaction and returns read data. It sits between the requesters and the only instance of `ram3`, and is the sole driver of the RAM control pins.

---
 rtl/ram3_ctrl_pkg.sv | 18 +
 rtl/ram3_arb_pick.sv | 50 +++++
 rtl/ram3_arb.sv | 144 ++++++++++++++
 tb/tb_ram3_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram3_ctrl_pkg.sv
// Shared types and default widths for the ram3 two-port access controller.
package ram3_ctrl_pkg;

    localparam int unsigned DefaultAddrW = 10;
    localparam int unsigned DefaultDataW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StAck
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PortZero = 1'b0;
    localparam port_id_t PortOne  = 1'b1;

endpackage

// File: rtl/ram3_arb_pick.sv
// Winner select between the two requesters. Define ARB_ROUND_ROBIN_EN for round-robin with a
// last-served pointer; otherwise port 0 has fixed priority and no state is built.
module ram3_arb_pick
    import ram3_ctrl_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic req0,
    input  logic req1,
    output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
    port_id_t last_q, last_d;

    // On a tie the port that was not served last wins.
    always_comb begin
        winner = PortZero;
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = PortOne;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_en) begin
            last_d = winner;
        end
    end

    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PortOne;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        winner = (!req0 && req1) ? PortOne : PortZero;
    end
`endif

endmodule

// File: rtl/ram3_arb.sv
// Two-port req/ack access controller for the single-port ram3. Arbitration policy is set by
// ARB_ROUND_ROBIN_EN (defined: round-robin, undefined: port 0 fixed priority).
module ram3_arb
    import ram3_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_e            state_q, state_d;
    port_id_t          port_q, port_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              winner;
    logic              any_req;

    assign any_req = req0 || req1;

    ram3_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en ((state_q == StIdle) && any_req),
`endif
        .req0     (req0),
        .req1     (req1),
        .winner   (winner)
    );

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        din_d    = '0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    port_d  = winner;
                    cs_d    = 1'b1;
                    wr_d    = (winner == PortOne) ? we1 : we0;
                    addr_d  = (winner == PortOne) ? addr1 : addr0;
                    din_d   = (winner == PortOne) ? wdata1 : wdata0;
                end
            end
            StAccess: begin
                state_d = StAck;
                ack0_d  = (port_q == PortZero);
                ack1_d  = (port_q == PortOne);
                // ram_dout is combinational on addr_q, so it is valid during ACCESS.
                if (!wr_q) begin
                    if (port_q == PortOne) begin
                        rdata1_d = ram_dout;
                    end else begin
                        rdata0_d = ram_dout;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            port_q   <= PortZero;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign ram_cs   = cs_q;
    assign ram_wr   = wr_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram3_arb.sv
// Self-checking bench for ram3_arb: behavioural RAM plus a transaction-level reference model.
module tb_ram3_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       ram_cs, ram_wr;
    logic [9:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       busy;

    int n_checks = 0;
    int n_errs   = 0;

    // ram3 stand-in: combinational read, write on the clock edge.
    logic [7:0] ram_mem [1024];
    assign ram_dout = ram_mem[ram_addr];
    always @(posedge clk) if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_din;

    // Reference model state.
    logic [7:0] ref_mem   [1024];
    logic [7:0] ref_rdata [2];
    int         ref_last;
    logic       t_we   [2];
    logic [9:0] t_addr [2];
    logic [7:0] t_data [2];
    logic [9:0] written [$];

    always #5 clk = ~clk;

    ram3_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .ram_cs   (ram_cs),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (ref_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    // Follows one granted transaction from the sampling edge to the return to IDLE.
    task automatic expect_grant(input int p);
        tick();
        check("acc_cs", ram_cs, 1);
        check("acc_wr", ram_wr, t_we[p]);
        check("acc_addr", ram_addr, t_addr[p]);
        if (t_we[p]) check("acc_din", ram_din, t_data[p]);
        check("acc_busy", busy, 1);
        check("acc_ack", {ack1, ack0}, 0);
        if (t_we[p]) ref_mem[t_addr[p]] = t_data[p];
        else ref_rdata[p] = ref_mem[t_addr[p]];
        ref_last = p;
        tick();
        check("ack", {ack1, ack0}, (p == 0) ? 2'b01 : 2'b10);
        check("ack_ram", {ram_cs, ram_wr, ram_addr, ram_din}, 0);
        check("ack_busy", busy, 1);
        check("rdata0", rdata0, ref_rdata[0]);
        check("rdata1", rdata1, ref_rdata[1]);
        tick();
        check("idle", {busy, ram_cs, ack1, ack0}, 0);
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic [9:0] a,
                         input logic [7:0] d);
        t_we[p] = w; t_addr[p] = a; t_data[p] = d;
        if (p == 0) begin
            req0 = v; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = v; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    // Raises the selected requests together and follows them to completion in model order.
    task automatic run_pair(input logic v0, input logic v1);
        int first;
        first = pick(v0, v1);
        expect_grant(first);
        drop(first);
        if (v0 && v1) begin
            expect_grant(1 - first);
            drop(1 - first);
        end
    endtask

    task automatic one(input int p, input logic w, input logic [9:0] a, input logic [7:0] d);
        drive(p, 1'b1, w, a, d);
        run_pair(p == 0, p == 1);
        if (w) written.push_back(a);
    endtask

    logic prev_cs = 1'b0;
    logic mon_en  = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("cs_twice", ram_cs & prev_cs, 0);
            check("cs_busy", ram_cs & ~busy, 0);
        end
        prev_cs <= ram_cs;
    end

    initial begin
        logic v0, v1;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        ref_last = 1;
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
        repeat (2) tick();
        check("rst_ack", {ack1, ack0}, 0);
        check("rst_busy", busy, 0);
        check("rst_ram", {ram_cs, ram_wr, ram_addr, ram_din}, 0);
        check("rst_rdata", {rdata1, rdata0}, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Port 0 write, port 1 read-back.
        one(0, 1'b1, 10'd2, 8'h04);
        one(1, 1'b0, 10'd2, 8'h00);

        // Simultaneous writes, then read-back.
        drive(0, 1'b1, 1'b1, 10'd4, 8'h08);
        drive(1, 1'b1, 1'b1, 10'd12, 8'h0A);
        run_pair(1'b1, 1'b1);
        written.push_back(10'd4);
        written.push_back(10'd12);
        one(0, 1'b0, 10'd4, 8'h00);
        one(1, 1'b0, 10'd12, 8'h00);

        // Address extremes.
        one(0, 1'b1, 10'h3FF, 8'hFF);
        one(1, 1'b1, 10'h000, 8'h11);
        one(0, 1'b0, 10'h3FF, 8'h00);
        one(1, 1'b0, 10'h000, 8'h00);

        // A write must leave the port's previous read data in place.
        one(0, 1'b1, 10'd100, 8'h5A);

        // Both requests held across several grants.
        drive(0, 1'b1, 1'b0, 10'd4, 8'h00);
        drive(1, 1'b1, 1'b0, 10'd12, 8'h00);
        for (int i = 0; i < 6; i++) expect_grant(pick(1'b1, 1'b1));
        drop(0);
        drop(1);
        tick();
        check("cont_done", {busy, ram_cs}, 0);

        // Reset during the ACCESS cycle of a port 0 read.
        drive(0, 1'b1, 1'b0, 10'd2, 8'h00);
        tick();
        check("rst_mid_cs", ram_cs, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_ack", ack0, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cs0", ram_cs, 0);
        check("rst_mid_rdata", {rdata1, rdata0}, 0);
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
        ref_last = 1;
        rst = 1'b0;
        run_pair(1'b1, 1'b0);

        // Random traffic; reads only target addresses already written.
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            for (int p = 0; p < 2; p++) begin
                logic       w;
                logic [9:0] a;
                w = 1'($urandom_range(0, 1));
                a = written[$urandom_range(0, written.size() - 1)];
                if (w) a = 10'($urandom_range(0, 1023));
                drive(p, (p == 0) ? v0 : v1, w, a, 8'($urandom));
            end
            run_pair(v0, v1);
            for (int p = 0; p < 2; p++)
                if (((p == 0) ? v0 : v1) && t_we[p]) written.push_back(t_addr[p]);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
